// File: rtl/channel_serializer_pkg.sv
// Shared defaults, counter-width helper and FSM state encoding for the
// channel serializer and its pixel FIFO.
package channel_serializer_pkg;

  localparam int DEF_DATA_WIDHT = 32;
  localparam int DEF_CHANNEL    = 128;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_IMG_WIDHT  = 44;
  localparam int DEF_IMG_HEIGHT = 44;

  localparam int CH_CNT_W  = $clog2(DEF_CHANNEL);
  localparam int PIX_CNT_W = $clog2(DEF_IMG_WIDHT * DEF_IMG_HEIGHT);
  localparam int LVL_W     = $clog2(DEF_FIFO_DEPTH + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wide_fifo.sv
// Synchronous FIFO of whole pixels; dout is a register loaded on pop and
// doubles as the serializer's holding register.
module wide_fifo
  import channel_serializer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             din_i,
  output logic [WIDTH-1:0]             dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int AW = cnt_w(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a pixel when a slot frees up on the same edge.
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  // NOTE: storage is left unreset; pointers and level define validity, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      dout_q  <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        dout_q <= mem_q[rd_q];
      end
      level_q <= level_d;
    end
  end

  assign dout_o  = dout_q;
  assign level_o = level_q;

endmodule

// File: rtl/channel_serializer.sv
// Re-streams wide per-pixel words as one channel word per cycle under a
// valid/ready handshake, with pixel buffering and sticky overflow.
module channel_serializer
  import channel_serializer_pkg::*;
#(
  parameter int DATA_WIDHT = DEF_DATA_WIDHT,
  parameter int CHANNEL    = DEF_CHANNEL,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int IMG_WIDHT  = DEF_IMG_WIDHT,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDHT*CHANNEL-1:0]      Data_In,
  input  logic                               Valid_In,
  input  logic                               Ready_In,
  output logic [DATA_WIDHT-1:0]              Data_Out,
  output logic                               Valid_Out,
  output logic                               Last_Pixel,
  output logic                               Last_Frame,
  output logic                               Overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    Fifo_Level
);

  localparam int NPIX = IMG_WIDHT * IMG_HEIGHT;
  localparam int CW   = cnt_w(CHANNEL);
  localparam int PW   = cnt_w(NPIX);

  state_e                        state_q, state_d;
  logic [CW-1:0]                 ch_q, ch_d;
  logic [PW-1:0]                 pix_q, pix_d;
  logic                          ovf_q, ovf_d;
  logic                          pop, full, empty, last_ch;
  logic [DATA_WIDHT*CHANNEL-1:0] hold;

  wide_fifo #(
    .WIDTH (DATA_WIDHT * CHANNEL),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (Valid_In),
    .pop_i   (pop),
    .din_i   (Data_In),
    .dout_o  (hold),
    .full_o  (full),
    .empty_o (empty),
    .level_o (Fifo_Level)
  );

  assign last_ch = (ch_q == CW'(CHANNEL - 1));

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          ch_d    = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (Ready_In) begin
          if (last_ch) begin
            pix_d = (pix_q == PW'(NPIX - 1)) ? '0 : pix_q + 1'b1;
            ch_d  = '0;
            // Back-to-back pixels: refill the holding register on the final word.
            if (!empty) pop = 1'b1;
            else        state_d = ST_IDLE;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ovf_d = ovf_q | (Valid_In && full && !pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      pix_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decode flops only; no input reaches an output combinationally.
  assign Valid_Out  = (state_q == ST_SEND);
  assign Data_Out   = Valid_Out ? hold[int'(ch_q) * DATA_WIDHT +: DATA_WIDHT] : '0;
  assign Last_Pixel = Valid_Out && last_ch;
  assign Last_Frame = Last_Pixel && (pix_q == PW'(NPIX - 1));
  assign Overflow   = ovf_q;

endmodule

// File: tb/tb_channel_serializer.sv
// Scoreboard bench: each accepted pixel queues its expected words; a
// negedge monitor pops and compares on every transfer.
module tb_channel_serializer;

  localparam int DW    = 32;
  localparam int CH    = 128;
  localparam int DEPTH = 4;
  localparam int IW    = 4;
  localparam int IH    = 3;
  localparam int NPIX  = IW * IH;
  localparam int LW    = $clog2(DEPTH + 1);

  typedef logic [DW*CH-1:0] pixel_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          lp;
    logic          lf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  pixel_t        Data_In;
  logic          Valid_In;
  logic          Ready_In;
  logic [DW-1:0] Data_Out;
  logic          Valid_Out;
  logic          Last_Pixel;
  logic          Last_Frame;
  logic          Overflow;
  logic [LW-1:0] Fifo_Level;

  int            n_checks = 0;
  int            n_errors = 0;
  exp_t          sb_q[$];
  exp_t          mon_e;
  int            acc_pix  = 0;
  int            lf_seen  = 0;
  int            cur_run  = 0;
  int            max_run  = 0;
  int            max_lvl  = 0;
  bit            held_v   = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_lp, held_lf;

  channel_serializer #(
    .DATA_WIDHT (DW),
    .CHANNEL    (CH),
    .FIFO_DEPTH (DEPTH),
    .IMG_WIDHT  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Data_In    (Data_In),
    .Valid_In   (Valid_In),
    .Ready_In   (Ready_In),
    .Data_Out   (Data_Out),
    .Valid_Out  (Valid_Out),
    .Last_Pixel (Last_Pixel),
    .Last_Frame (Last_Frame),
    .Overflow   (Overflow),
    .Fifo_Level (Fifo_Level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic pixel_t make_pixel(input logic [DW-1:0] base);
    pixel_t p;
    for (int k = 0; k < CH; k++) p[k*DW +: DW] = base + DW'(k);
    return p;
  endfunction

  function automatic pixel_t random_pixel();
    pixel_t p;
    for (int k = 0; k < CH; k++) p[k*DW +: DW] = DW'($urandom());
    return p;
  endfunction

  // Drives one pixel for one cycle; returns 1 ns after the sampling edge.
  task automatic push_pixel(input pixel_t px, input bit drop);
    exp_t e;
    Valid_In = 1'b1;
    Data_In  = px;
    if (!drop) begin
      for (int k = 0; k < CH; k++) begin
        e.data = px[k*DW +: DW];
        e.lp   = (k == CH - 1);
        e.lf   = (k == CH - 1) && (acc_pix % NPIX == NPIX - 1);
        sb_q.push_back(e);
      end
      acc_pix++;
    end
    @(posedge clk);
    #1;
    Valid_In = 1'b0;
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((sb_q.size() != 0 || Valid_Out) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 64'(n < limit), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  64'(Data_Out),   64'(0));
    check({tag, "_valid"}, 64'(Valid_Out),  64'(0));
    check({tag, "_lp"},    64'(Last_Pixel), 64'(0));
    check({tag, "_lf"},    64'(Last_Frame), 64'(0));
    check({tag, "_ovf"},   64'(Overflow),   64'(0));
    check({tag, "_level"}, 64'(Fifo_Level), 64'(0));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        held_v  = 1'b0;
        cur_run = 0;
      end else begin
        if (held_v) begin
          check("stall_valid", 64'(Valid_Out),  64'(1));
          check("stall_data",  64'(Data_Out),   64'(held_d));
          check("stall_lp",    64'(Last_Pixel), 64'(held_lp));
          check("stall_lf",    64'(Last_Frame), 64'(held_lf));
        end
        held_v  = Valid_Out && !Ready_In;
        held_d  = Data_Out;
        held_lp = Last_Pixel;
        held_lf = Last_Frame;
        cur_run = Valid_Out ? cur_run + 1 : 0;
        if (cur_run > max_run) max_run = cur_run;
        if (int'(Fifo_Level) > max_lvl) max_lvl = int'(Fifo_Level);
        if (Valid_Out && Ready_In) begin
          if (sb_q.size() == 0) begin
            check("spurious_word", 64'(Valid_Out), 64'(0));
          end else begin
            mon_e = sb_q.pop_front();
            check("word_data", 64'(Data_Out),   64'(mon_e.data));
            check("word_lp",   64'(Last_Pixel), 64'(mon_e.lp));
            check("word_lf",   64'(Last_Frame), 64'(mon_e.lf));
            if (Last_Frame) lf_seen++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d words pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bit [0:3] pat;
    int       n;
    int       lf0;

    rst      = 1'b0;
    Valid_In = 1'b0;
    Data_In  = '0;
    Ready_In = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Single pixel: one-edge latency, then 128 ordered words.
    push_pixel(make_pixel(32'h1000_0000), 1'b0);
    check("t1_valid_before_pop", 64'(Valid_Out),  64'(0));
    check("t1_level_after_push", 64'(Fifo_Level), 64'(1));
    @(posedge clk);
    #1;
    check("t1_valid_after_pop",  64'(Valid_Out),  64'(1));
    check("t1_first_word",       64'(Data_Out),   64'(32'h1000_0000));
    drain("t1_drain", 400);
    check("t1_idle_after",       64'(Valid_Out),  64'(0));

    // Ready toggling 1,0,0,1 across one pixel.
    pat = 4'b1001;
    push_pixel(make_pixel(32'h2000_0000), 1'b0);
    n = 0;
    while ((sb_q.size() != 0 || Valid_Out) && n < 1000) begin
      Ready_In = pat[n % 4];
      @(posedge clk);
      #1;
      n++;
    end
    check("t2_drain", 64'(n < 1000), 64'(1));
    Ready_In = 1'b1;

    // Three back-to-back pixels stream without a bubble.
    max_run = 0;
    max_lvl = 0;
    for (int p = 0; p < 3; p++) push_pixel(make_pixel(32'h3000_0000 + DW'(p << 16)), 1'b0);
    drain("t3_drain", 600);
    check("t3_contiguous_words", 64'(max_run), 64'(3 * CH));
    check("t3_level_peak",       64'(max_lvl), 64'(2));

    // Stalled output: FIFO saturates, sixth pixel is dropped.
    Ready_In = 1'b0;
    for (int p = 1; p <= 5; p++) push_pixel(make_pixel(32'h4000_0000 + DW'(p << 24)), 1'b0);
    check("t4_level_full",     64'(Fifo_Level), 64'(DEPTH));
    check("t4_no_ovf_yet",     64'(Overflow),   64'(0));
    push_pixel(make_pixel(32'h4600_0000), 1'b1);
    check("t4_level_held",     64'(Fifo_Level), 64'(DEPTH));
    check("t4_ovf_set",        64'(Overflow),   64'(1));
    check("t4_hold_pixel1",    64'(Data_Out),   64'(32'h4100_0000));
    Ready_In = 1'b1;
    drain("t4_drain", 1200);
    check("t4_ovf_sticky",     64'(Overflow),   64'(1));

    // Reset in the middle of a pixel with two pixels queued.
    for (int p = 0; p < 3; p++) push_pixel(make_pixel(32'hA000_0000 + DW'(p << 24)), 1'b0);
    n = 0;
    while (!(Valid_Out && Data_Out == 32'hA000_003C) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_reach_ch60",   64'(n < 500),    64'(1));
    check("t5_level_queued", 64'(Fifo_Level), 64'(2));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("t5_mid_reset");
    sb_q.delete();
    acc_pix = 0;
    rst     = 1'b1;
    push_pixel(make_pixel(32'hC000_0000), 1'b0);
    @(posedge clk);
    #1;
    check("t5_restart_valid", 64'(Valid_Out), 64'(1));
    check("t5_restart_ch0",   64'(Data_Out),  64'(32'hC000_0000));
    drain("t5_drain", 400);

    // Frame boundary: one pixel every CH cycles across a frame wrap.
    lf0 = lf_seen;
    for (int p = 0; p <= NPIX; p++) begin
      push_pixel(random_pixel(), 1'b0);
      repeat (CH - 1) @(posedge clk);
      #1;
    end
    drain("t6_drain", 500);
    check("t6_last_frame_once", 64'(lf_seen - lf0), 64'(1));
    check("t6_no_overflow",     64'(Overflow),      64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
